// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state, default sizes and write priority for regfile_mp
package regfile_pkg;
    typedef enum logic {RF_CLEAR, RF_RUN} rf_state_e;
    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH = 32;
    localparam int RF_WR_PRIO_PORT = 1;
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port; REGFILE_MP_BYPASS_EN adds write forwarding
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH = RF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic                    run_i,
    input  logic [ADDR_W-1:0]       raddr_i,
    input  logic [DEPTH*DATA_W-1:0] mem_i,
`ifdef REGFILE_MP_BYPASS_EN
    input  logic                    we0_i,
    input  logic [ADDR_W-1:0]       waddr0_i,
    input  logic [DATA_W-1:0]       wdata0_i,
    input  logic                    we1_i,
    input  logic [ADDR_W-1:0]       waddr1_i,
    input  logic [DATA_W-1:0]       wdata1_i,
`endif
    output logic [DATA_W-1:0]       rdata_o
);
    logic [DATA_W-1:0] stored;
    logic zero_hit;
    assign stored = mem_i[int'(raddr_i)*DATA_W +: DATA_W];
    assign zero_hit = (ZERO_REG != 0) && (raddr_i == '0);
`ifdef REGFILE_MP_BYPASS_EN
    // port 1 is checked first so it wins when both ports hit this address
    assign rdata_o = (!run_i || zero_hit) ? '0 :
                     (we1_i && waddr1_i == raddr_i) ? wdata1_i :
                     (we0_i && waddr0_i == raddr_i) ? wdata0_i : stored;
`else
    assign rdata_o = (!run_i || zero_hit) ? '0 : stored;
`endif
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with hardware clear; REGFILE_MP_BYPASS_EN enables write-to-read bypass
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int DEPTH = RF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata
);
    rf_state_e state_q;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH*DATA_W-1:0] mem_flat;
    logic run, wr0_ok, wr1_ok;
    assign run = (state_q == RF_RUN);
    assign init_done = run;
    assign clr_ptr_d = clr_ptr_q + 1'b1;
    assign wr0_ok = we0 && !(ZERO_REG != 0 && waddr0 == '0);
    assign wr1_ok = we1 && !(ZERO_REG != 0 && waddr1 == '0);
    // port 1 is assigned last so it overrides port 0 on an address collision
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            clr_ptr_q <= '0;
        end else if (state_q == RF_CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
            clr_ptr_q <= clr_ptr_d;
            if (clr_ptr_q == ADDR_W'(DEPTH-1)) state_q <= RF_RUN;
        end else begin
            if (wr0_ok) mem_q[waddr0] <= wdata0;
            if (wr1_ok) mem_q[waddr1] <= wdata1;
        end
    end
    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign mem_flat[i*DATA_W +: DATA_W] = mem_q[i];
    end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)
        ) u_rd (
            .run_i(run),
            .raddr_i(raddr[k*ADDR_W +: ADDR_W]),
            .mem_i(mem_flat),
`ifdef REGFILE_MP_BYPASS_EN
            .we0_i(wr0_ok),
            .waddr0_i(waddr0),
            .wdata0_i(wdata0),
            .we1_i(wr1_ok),
            .waddr1_i(waddr1),
            .wdata1_i(wdata1),
`endif
            .rdata_o(rdata[k*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of clear sequence, writes, collisions, zero register and bypass
module tb_regfile_mp;
    logic clk = 0, rst = 1;
    logic we0 = 0, we1 = 0;
    logic [4:0] waddr0 = 0, waddr1 = 0;
    logic [31:0] wdata0 = 0, wdata1 = 0;
    logic [9:0] raddr = 0;
    logic [63:0] rdata, rdata_nz;
    logic init_done, init_done_nz;
    int checks = 0, failures = 0;

    regfile_mp #(.ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata)
    );
    regfile_mp #(.ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst(rst), .init_done(init_done_nz),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_nz)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done && n < 40) begin
            step();
            n++;
        end
        check(tag, n, 32);
        check({tag, "_nz"}, {31'd0, init_done_nz}, 1);
    endtask

    initial begin
        logic [31:0] exp_by;
        step();
        step();
        check("rst_init_done", {31'd0, init_done}, 0);
        check("rst_rdata0", rdata[31:0], 0);
        check("rst_rdata1", rdata[63:32], 0);
        rst = 0;
        wait_init("first_clear_len");
        for (int i = 0; i < 32; i++) begin
            we0 = 1;
            waddr0 = 5'(i);
            wdata0 = (i == 0) ? 32'hFFFF_FFFF : (32'hA5A5_0000 | i);
            step();
        end
        we0 = 0;
        raddr = {5'd17, 5'd0};
        #1;
        check("zero_reg_read", rdata[31:0], 0);
        check("nonzero_reg_read", rdata_nz[31:0], 32'hFFFF_FFFF);
        check("garbage_17", rdata[63:32], 32'hA5A5_0011);
        rst = 1;
        step();
        check("pulse_init_low", {31'd0, init_done}, 0);
        check("pulse_clear_rdata", rdata[63:32], 0);
        rst = 0;
        wait_init("pulse_clear_len");
        for (int i = 0; i < 32; i++) begin
            raddr = {5'd0, 5'(i)};
            #1;
            check($sformatf("cleared_%0d", i), rdata[31:0], 0);
            check($sformatf("cleared_nz_%0d", i), rdata_nz[31:0], 0);
        end
        we0 = 1;
        waddr0 = 5;
        wdata0 = 32'hDEAD_BEEF;
        raddr = {5'd6, 5'd5};
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        check("same_cycle_5", rdata[31:0], 32'hDEAD_BEEF);
`else
        check("same_cycle_5", rdata[31:0], 0);
`endif
        step();
        we0 = 0;
        #1;
        check("basic_5", rdata[31:0], 32'hDEAD_BEEF);
        check("basic_6", rdata[63:32], 0);
        we0 = 1;
        we1 = 1;
        waddr0 = 7;
        waddr1 = 7;
        wdata0 = 32'h1111_1111;
        wdata1 = 32'h2222_2222;
        step();
        waddr0 = 10;
        waddr1 = 11;
        wdata0 = 32'h0000_AAAA;
        wdata1 = 32'h0000_BBBB;
        step();
        we0 = 0;
        we1 = 0;
        raddr = {5'd10, 5'd7};
        #1;
        check("collision_7", rdata[31:0], 32'h2222_2222);
        check("dual_write_10", rdata[63:32], 32'h0000_AAAA);
        raddr = {5'd11, 5'd5};
        #1;
        check("dual_write_11", rdata[63:32], 32'h0000_BBBB);
        we0 = 1;
        waddr0 = 9;
        wdata0 = 32'h0000_00C3;
        raddr = {5'd9, 5'd0};
        #1;
`ifdef REGFILE_MP_BYPASS_EN
        exp_by = 32'h0000_00C3;
`else
        exp_by = 32'h0;
`endif
        check("bypass_9", rdata[63:32], exp_by);
        step();
        we0 = 0;
        #1;
        check("after_bypass_9", rdata[63:32], 32'h0000_00C3);
        rst = 1;
        step();
        rst = 0;
        we0 = 1;
        waddr0 = 3;
        wdata0 = 32'h0000_00AB;
        raddr = {5'd3, 5'd5};
        for (int i = 0; i < 10; i++) step();
        check("mid_clear_init_low", {31'd0, init_done}, 0);
        check("mid_clear_rdata", rdata[31:0], 0);
        rst = 1;
        step();
        rst = 0;
        wait_init("restart_clear_len");
        we0 = 0;
        #1;
        check("clear_write_dropped_3", rdata[63:32], 0);
        check("after_restart_5", rdata[31:0], 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
